// File: rtl/video_timing_ctrl.sv
// video_timing_ctrl: programmable raster timing generator.
// Runs horizontal/vertical counters from shadow timing registers and
// registers the pixel coordinates, DE and sync decodes for the TMDS
// encoders. New timing is staged, committed, and applied only on the
// last pixel of a frame so a mode change never tears a frame.
module video_timing_ctrl #(
   parameter int unsigned H_ACTIVE = 1360,
   parameter int unsigned H_FP     = 64,
   parameter int unsigned H_SYNC   = 112,
   parameter int unsigned H_BP     = 256,
   parameter int unsigned V_ACTIVE = 768,
   parameter int unsigned V_FP     = 4,
   parameter int unsigned V_SYNC   = 6,
   parameter int unsigned V_BP     = 17
) (
   input  logic        pix_clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        cfg_wr,
   input  logic [2:0]  cfg_addr,
   input  logic [12:0] cfg_data,
   input  logic        cfg_commit,
   output logic        cfg_pending,
   output logic        cfg_err,
   output logic [12:0] x,
   output logic [12:0] y,
   output logic        de,
   output logic        hsync,
   output logic        vsync,
   output logic        frame_start,
   output logic        line_start
);

   // Register file index order: 0 H_ACTIVE .. 7 V_BP.
   localparam logic [7:0][12:0] CFG_RST = {
      13'(V_BP), 13'(V_SYNC), 13'(V_FP), 13'(V_ACTIVE),
      13'(H_BP), 13'(H_SYNC), 13'(H_FP), 13'(H_ACTIVE)
   };

   typedef enum logic {ST_OFF = 1'b0, ST_RUN = 1'b1} state_e;

   state_e state_q, state_d;

   logic [12:0]      hcnt_q, hcnt_d;
   logic [12:0]      vcnt_q, vcnt_d;
   logic [7:0][12:0] stg_q, stg_d;
   logic [7:0][12:0] shd_q, shd_d;
   logic             pend_q, pend_d;
   logic             err_q, err_d;

   logic [12:0] x_q, x_d, y_q, y_d;
   logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d, ls_q, ls_d;

   // Derived timing from the shadow registers.
   logic [12:0] h_tot, v_tot, h_ss, h_se, v_ss, v_se;
   logic        run, h_last, v_last, apply, any_zero;

   assign h_ss  = shd_q[0] + shd_q[1];
   assign h_se  = h_ss + shd_q[2];
   assign h_tot = h_se + shd_q[3];
   assign v_ss  = shd_q[4] + shd_q[5];
   assign v_se  = v_ss + shd_q[6];
   assign v_tot = v_se + shd_q[7];

   // Counters only move while the FSM is in RUN and enable is still high;
   // a low enable in RUN drops straight to OFF on this edge.
   assign run    = (state_q == ST_RUN) && en;
   assign h_last = (hcnt_q == h_tot - 13'd1);
   assign v_last = (vcnt_q == v_tot - 13'd1);

   // Shadow update point: last pixel of a running frame, or any edge in OFF.
   assign apply  = pend_q && ((state_q == ST_OFF) || (run && h_last && v_last));

   // FSM state register.
   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_OFF;
      else        state_q <= state_d;
   end

   // FSM next state: enable is the only control.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_OFF:  if (en)  state_d = ST_RUN;
         ST_RUN:  if (!en) state_d = ST_OFF;
         default: state_d = ST_OFF;
      endcase
   end

   // Raster counters: h wraps at h_total-1 and carries into v.
   always_comb begin
      hcnt_d = 13'd0;
      vcnt_d = 13'd0;
      if (run) begin
         if (h_last) begin
            hcnt_d = 13'd0;
            vcnt_d = v_last ? 13'd0 : vcnt_q + 13'd1;
         end else begin
            hcnt_d = hcnt_q + 13'd1;
            vcnt_d = vcnt_q;
         end
      end
   end

   // Output decodes from the current counters, registered one edge later.
   always_comb begin
      x_d  = 13'd0;
      y_d  = 13'd0;
      de_d = 1'b0;
      hs_d = 1'b0;
      vs_d = 1'b0;
      fs_d = 1'b0;
      ls_d = 1'b0;
      if (run) begin
         x_d  = hcnt_q;
         y_d  = vcnt_q;
         de_d = (hcnt_q < shd_q[0]) && (vcnt_q < shd_q[4]);
         hs_d = (hcnt_q >= h_ss) && (hcnt_q < h_se);
         vs_d = (vcnt_q >= v_ss) && (vcnt_q < v_se);
         fs_d = (hcnt_q == 13'd0) && (vcnt_q == 13'd0);
         ls_d = (hcnt_q == 13'd0);
      end
   end

   // Any zero field in staging makes a commit illegal.
   always_comb begin
      any_zero = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (stg_q[i] == 13'd0) any_zero = 1'b1;
      end
   end

   // Staging writes, commit handshake and shadow transfer. The shadow
   // copies the registered staging value, so a write on the apply edge
   // waits for the next commit.
   always_comb begin
      stg_d  = stg_q;
      shd_d  = shd_q;
      pend_d = pend_q;
      err_d  = 1'b0;
      if (cfg_wr) stg_d[cfg_addr] = cfg_data;
      if (apply) begin
         shd_d  = stg_q;
         pend_d = 1'b0;
      end else if (cfg_commit && !pend_q) begin
         if (any_zero) err_d  = 1'b1;
         else          pend_d = 1'b1;
      end
   end

   // Datapath and configuration registers.
   always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt_q <= 13'd0;
         vcnt_q <= 13'd0;
         stg_q  <= CFG_RST;
         shd_q  <= CFG_RST;
         pend_q <= 1'b0;
         err_q  <= 1'b0;
         x_q    <= 13'd0;
         y_q    <= 13'd0;
         de_q   <= 1'b0;
         hs_q   <= 1'b0;
         vs_q   <= 1'b0;
         fs_q   <= 1'b0;
         ls_q   <= 1'b0;
      end else begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
         stg_q  <= stg_d;
         shd_q  <= shd_d;
         pend_q <= pend_d;
         err_q  <= err_d;
         x_q    <= x_d;
         y_q    <= y_d;
         de_q   <= de_d;
         hs_q   <= hs_d;
         vs_q   <= vs_d;
         fs_q   <= fs_d;
         ls_q   <= ls_d;
      end
   end

   assign cfg_pending = pend_q;
   assign cfg_err     = err_q;
   assign x           = x_q;
   assign y           = y_q;
   assign de          = de_q;
   assign hsync       = hs_q;
   assign vsync       = vs_q;
   assign frame_start = fs_q;
   assign line_start  = ls_q;

endmodule

// File: doc/video_timing_ctrl.md
# video_timing_ctrl

Programmable raster timing controller. It sequences the pixel pipeline: pixel coordinates go to the pattern/game generator, and DE, hSync and vSync go to the three TMDS channel encoders. Mode timing lives in shadow registers, loaded through a staging/commit handshake. A commit takes effect only at a frame boundary, so a mode change never tears a frame.

## Interface
Parameters (power-on/reset values of the shadow and staging registers):
- H_ACTIVE, 1360, visible pixels per line
- H_FP, 64, horizontal front porch
- H_SYNC, 112, hSync width
- H_BP, 256, horizontal back porch
- V_ACTIVE, 768, visible lines
- V_FP, 4, vertical front porch
- V_SYNC, 6, vSync width
- V_BP, 17, vertical back porch

Ports:
- pix_clk  in  1  pixel clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  run enable
- cfg_wr  in  1  staging write strobe
- cfg_addr  in  3  register index: 0 H_ACTIVE, 1 H_FP, 2 H_SYNC, 3 H_BP, 4 V_ACTIVE, 5 V_FP, 6 V_SYNC, 7 V_BP
- cfg_data  in  13  write value
- cfg_commit  in  1  request staging→shadow transfer
- cfg_pending  out  1  commit accepted, not yet applied
- cfg_err  out  1  one-cycle pulse: commit rejected
- x  out  13  pixel column
- y  out  13  pixel row
- de  out  1  active video
- hsync  out  1  horizontal sync, active high (TMDS C0)
- vsync  out  1  vertical sync, active high (TMDS C1)
- frame_start  out  1  one-cycle pulse at x=0, y=0
- line_start  out  1  one-cycle pulse at x=0

## Operation
- Totals: h_total = H_ACTIVE+H_FP+H_SYNC+H_BP; v_total likewise, both 13-bit.
- h_cnt counts 0..h_total-1 and wraps to 0. v_cnt advances when h_cnt wraps, and wraps itself at v_total-1.
- FSM has two states:
  - OFF: counters held at 0; all outputs 0.
  - RUN: counters free-run.
- Transitions: OFF→RUN when en=1. RUN→OFF when en=0; this is immediate and abandons the frame mid-line. Re-entering RUN always starts at (0,0).
- Decodes, all taken from the counters:
  - de = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE
  - hsync = H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC
  - vsync uses the same form on v_cnt
  - x = h_cnt, y = v_cnt
- Staging: cfg_wr writes cfg_data into staging[cfg_addr]. The shadow registers do not change.
- Commit:
  - cfg_commit sets cfg_pending.
  - If any staging field is 0, the commit is rejected instead: cfg_err pulses, cfg_pending stays 0, and the shadow is unchanged.
- Apply point:
  - In RUN: the edge where h_cnt=h_total-1 and v_cnt=v_total-1.
  - In OFF: the next edge.
  - At the apply point shadow ← staging and cfg_pending clears.
- A cfg_commit while cfg_pending=1 is absorbed; only one pending flag exists.
- A cfg_wr on the same edge as the apply point is not copied to the shadow; it takes effect only with the next commit.
- A cfg_wr while cfg_pending=1 is allowed, and the written value is applied.
- Arithmetic is unsigned 13-bit. The implementation does not check totals beyond 8191.

## Timing
- Reset values:
  - Outputs: all outputs 0, state OFF.
  - Counters: 0.
  - Registers: shadow and staging = parameters.
- All outputs are registered and mutually aligned. Each output reflects the counter value of the previous edge, so latency is 1 pix_clk from counter to output.
- After en rises, the first edge moves to RUN. frame_start and the outputs for (0,0) appear on the second edge.
- cfg_err and cfg_pending are valid 1 cycle after cfg_commit.
- After the apply point, the first output sample using the new timing is (0,0) of the next frame.
- If rst_n is asserted mid-frame, everything returns to reset values at once. A pending commit is lost.

## Test plan
- Timing 4/1/2/1 by 3/1/1/1 (h_total 8, v_total 6), en=1:
  - de high for x 0..3 on y 0..2.
  - hsync high at x 5,6.
  - vsync high for all of y=4.
  - frame_start every 48 cycles.
  - line_start every 8.
- Defaults, en=1 for 2 frames → frame_start period 1792×795 = 1424640 cycles; de count per frame 1044480.
- Running with small timing:
  - Write H_ACTIVE=6 and commit mid-frame → cfg_pending=1 until the frame end; current frame still h_total 8.
  - Next frame has h_total 10 and de spans x 0..5.
- Commit with staging V_SYNC=0 → cfg_err pulse, cfg_pending=0, timing unchanged.
- en drops at x=2, y=1 → outputs 0 next cycle. en re-asserts → outputs restart at (0,0) with frame_start.
- rst_n low at mid-line while cfg_pending=1 → all outputs 0 and pending clear. After release, default timing is active.
